// File: rtl/regress_checker.sv
// regress_checker: latency-aligned expected-vs-DUT comparator with warm-up, counters and done/pass/fail flags
//
// Optional feature macro: REGRESS_CHECKER_DISPLAY_EN (per-compare log lines and $finish on completion;
// when undefined the block is silent and synthesizable)
//
// Ports:
//   clock            rising-edge clock
//   reset            asynchronous active-low reset
//   exp_valid        exp_data is valid for the stimulus applied this cycle
//   exp_data         reference-model value, presented in the stimulus cycle
//   dut_data         DUT output
//   cyc_cnt          cycles since reset release (saturating)
//   check_count      compares performed
//   err_count        mismatches seen (saturating)
//   first_err_cycle  cyc_cnt of the first mismatch
//   first_err_data   dut_data at the first mismatch
//   done/pass/fail   sticky status flags
module regress_checker #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1,
  parameter int WARMUP  = 5000,
  parameter int RUN     = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             exp_valid,
  input  logic [WIDTH-1:0] exp_data,
  input  logic [WIDTH-1:0] dut_data,
  output logic [31:0]      cyc_cnt,
  output logic [15:0]      check_count,
  output logic [15:0]      err_count,
  output logic [31:0]      first_err_cycle,
  output logic [WIDTH-1:0] first_err_data,
  output logic             done,
  output logic             pass,
  output logic             fail
);
  typedef enum logic [1:0] {ST_WARM, ST_CHECK, ST_DONE} state_t;
  state_t           state_q;
  logic [31:0]      cyc_q, fec_q;
  logic [15:0]      chk_q, err_q, err_d;
  logic [WIDTH-1:0] fed_q;
  logic             done_q, pass_q, fail_q;
  logic             d_valid, cmp, mism, last, warm_end;
  logic [WIDTH-1:0] d_data;
  // The delay line runs in every state so the first compare after warm-up already sees aligned data
  generate
    if (LATENCY == 0) begin : g_lat0
      assign d_valid = exp_valid;
      assign d_data  = exp_data;
    end else begin : g_lat
      logic [LATENCY-1:0] v_q;
      logic [WIDTH-1:0]   dat_q [LATENCY];
      always_ff @(posedge clock or negedge reset)
        if (!reset) begin
          v_q <= '0;
          for (int i = 0; i < LATENCY; i++) dat_q[i] <= '0;
        end else begin
          v_q[0]   <= exp_valid;
          dat_q[0] <= exp_data;
          for (int i = 1; i < LATENCY; i++) begin
            v_q[i]   <= v_q[i-1];
            dat_q[i] <= dat_q[i-1];
          end
        end
      assign d_valid = v_q[LATENCY-1];
      assign d_data  = dat_q[LATENCY-1];
    end
  endgenerate
  always_comb begin
    cmp      = (state_q == ST_CHECK) && d_valid;
    // Case inequality: X/Z on the DUT side is a mismatch in simulation
    mism     = cmp && (dut_data !== d_data);
    err_d    = (mism && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
    last     = cmp && ({1'b0, chk_q} + 17'd1 == 17'(RUN));
    // Leave warm-up on the edge where cyc_cnt becomes WARMUP
    warm_end = (state_q == ST_WARM) && ({1'b0, cyc_q} + 33'd1 >= 33'(WARMUP));
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= ST_WARM;
      cyc_q   <= '0;
      chk_q   <= '0;
      err_q   <= '0;
      fec_q   <= '0;
      fed_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      cyc_q <= (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;
      if (warm_end) begin
        state_q <= (RUN == 0) ? ST_DONE : ST_CHECK;
        if (RUN == 0) begin
          done_q <= 1'b1;
          pass_q <= 1'b1;
`ifdef REGRESS_CHECKER_DISPLAY_EN
          $display("PASS");
          $finish;
`endif
        end
      end
      if (cmp) begin
        chk_q <= chk_q + 16'd1;
        err_q <= err_d;
        if (mism && !fail_q) begin
          fec_q  <= cyc_q;
          fed_q  <= dut_data;
          fail_q <= 1'b1;
        end
`ifdef REGRESS_CHECKER_DISPLAY_EN
        $display("cycle:%4d exp:%2d y:%2d %s", cyc_q, $signed(d_data), $signed(dut_data), mism ? "ERR" : "OK");
`endif
        if (last) begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
          pass_q  <= (err_d == 16'd0);
`ifdef REGRESS_CHECKER_DISPLAY_EN
          if (err_d == 16'd0) $display("PASS");
          else $display("FAIL errors:%0d", err_d);
          $finish;
`endif
        end
      end
    end
  assign cyc_cnt         = cyc_q;
  assign check_count     = chk_q;
  assign err_count       = err_q;
  assign first_err_cycle = fec_q;
  assign first_err_data  = fed_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign fail            = fail_q;
endmodule

// File: tb/tb_regress_checker.sv
// tb_regress_checker: directed self-checking bench for regress_checker (LATENCY=1 and LATENCY=0 instances)
module tb_regress_checker;
  logic clk = 1'b0;
  logic rst_n;
  logic ev;
  logic [7:0] ed, a, a_q, a1, a1_q, dut0, dut1;
  logic xm, fm, tog, comb1;
  int tc, tests, fails;
  logic [31:0] cyc0, fec0, cyc1, fec1;
  logic [15:0] cc0, ec0, cc1, ec1;
  logic [7:0] fed0, fed1;
  logic dn0, ps0, fl0, dn1, ps1, fl1;
  always #5 clk = ~clk;
  // Stand-in DUTs: a register of a (instance 0) and either a wire or register of a1 (instance 1)
  always_ff @(posedge clk) begin
    a_q  <= a;
    a1_q <= a1;
  end
  assign dut0 = (xm && tc < 20) ? 8'hxx : (fm && tc == 25) ? 8'h0d : a_q;
  assign dut1 = comb1 ? a1 : a1_q;
  regress_checker #(.WIDTH(8), .LATENCY(1), .WARMUP(20), .RUN(10)) u0 (
    .clock(clk), .reset(rst_n), .exp_valid(ev), .exp_data(ed), .dut_data(dut0),
    .cyc_cnt(cyc0), .check_count(cc0), .err_count(ec0), .first_err_cycle(fec0),
    .first_err_data(fed0), .done(dn0), .pass(ps0), .fail(fl0));
  regress_checker #(.WIDTH(8), .LATENCY(0), .WARMUP(20), .RUN(10)) u1 (
    .clock(clk), .reset(rst_n), .exp_valid(1'b1), .exp_data(a1), .dut_data(dut1),
    .cyc_cnt(cyc1), .check_count(cc1), .err_count(ec1), .first_err_cycle(fec1),
    .first_err_data(fed1), .done(dn1), .pass(ps1), .fail(fl1));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive();
    ev = tog ? ~tc[0] : 1'b1;
    ed = 8'h0c;
    a  = 8'h0c;
    a1 = comb1 ? 8'hc3 : tc[7:0];
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    tc++;
    drive();
  endtask
  task automatic go_to(input int n);
    while (tc < n) tick();
  endtask
  task automatic restart();
    rst_n = 1'b0;
    tc = 0;
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tc = 0;
    drive();
  endtask
  initial begin
    tests = 0; fails = 0; tc = 0;
    xm = 0; fm = 0; tog = 0; comb1 = 1;
    rst_n = 1'b0;
    drive();
    @(posedge clk);
    #1;
    chk("rst_cyc", cyc0, 0);
    chk("rst_cc", cc0, 0);
    chk("rst_flags", {dn0, ps0, fl0}, 0);
    // Test 1 (+ LATENCY=0 combinational DUT on u1)
    restart();
    chk("t1_cyc0", cyc0, 0);
    go_to(20);
    chk("t1_warm_cc", cc0, 0);
    go_to(21);
    chk("t1_first_cc", cc0, 1);
    go_to(29);
    chk("t1_done_early", dn0, 0);
    go_to(30);
    chk("t1_cyc30", cyc0, 30);
    chk("t1_done_pass", {dn0, ps0, fl0}, 3'b110);
    chk("t1_cc", cc0, 10);
    chk("t1_ec", ec0, 0);
    chk("t6_comb_pass", {dn1, ps1, fl1}, 3'b110);
    go_to(35);
    chk("t1_frozen_cc", cc0, 10);
    chk("t1_cyc35", cyc0, 35);
    // Test 2 (+ LATENCY=0 against registered DUT on u1)
    fm = 1; comb1 = 0;
    restart();
    go_to(25);
    chk("t2_fail_pre", fl0, 0);
    go_to(26);
    chk("t2_fail_rise", fl0, 1);
    chk("t2_done_pre", dn0, 0);
    go_to(21);
    go_to(30);
    chk("t2_flags", {dn0, ps0, fl0}, 3'b101);
    chk("t2_ec", ec0, 1);
    chk("t2_fec", fec0, 25);
    chk("t2_fed", fed0, 8'h0d);
    chk("t6_reg_fec", fec1, 20);
    chk("t6_reg_fed", fed1, 8'h13);
    chk("t6_reg_ec", ec1, 10);
    chk("t6_reg_flags", {dn1, ps1, fl1}, 3'b101);
    // Test 3: X on dut_data during warm-up only
    fm = 0; xm = 1; comb1 = 1;
    restart();
    go_to(30);
    chk("t3_ec", ec0, 0);
    chk("t3_flags", {dn0, ps0, fl0}, 3'b110);
    // Test 4: exp_valid alternating from cycle 0
    xm = 0; tog = 1;
    restart();
    go_to(25);
    chk("t4_cc_mid", cc0, 2);
    go_to(39);
    chk("t4_done_early", dn0, 0);
    go_to(40);
    chk("t4_flags", {dn0, ps0, fl0}, 3'b110);
    chk("t4_cc", cc0, 10);
    // Test 5: reset mid-check
    tog = 0;
    restart();
    go_to(24);
    chk("t5_cc_pre", cc0, 4);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_cc", cc0, 0);
    chk("t5_rst_cyc", cyc0, 0);
    restart();
    go_to(20);
    chk("t5_warm_cc", cc0, 0);
    go_to(30);
    chk("t5_flags", {dn0, ps0, fl0}, 3'b110);
    chk("t5_cyc", cyc0, 30);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/regress_checker.md
Name: regress_checker

Overview:
- Response-side companion to the stimulus drivers in our per-primitive regression benches: receives the expected value (reference model output) and the DUT output, aligns them by a fixed latency, and compares them.
- Comparisons are suppressed during the GSR warm-up window.
- Counts checks and mismatches, and raises sticky done/pass/fail flags.
- Replaces per-cycle $display eyeballing so benches self-check.

Parameters:
- WIDTH, 8, data width of expected and DUT values.
- LATENCY, 1, DUT latency in cycles; legal range 0..8.
- WARMUP, 5000, cycles after reset release during which no compare occurs (GSR init).
- RUN, 10, number of valid compares to perform before done.

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- exp_valid  in  1  exp_data is a valid expected value for the stimulus applied this cycle.
- exp_data  in  WIDTH  expected value from the reference model, presented in the stimulus cycle.
- dut_data  in  WIDTH  DUT output.
- cyc_cnt  out  32  cycles since reset release, saturating at 32'hFFFFFFFF.
- check_count  out  16  compares performed.
- err_count  out  16  mismatches seen; saturates at 16'hFFFF.
- first_err_cycle  out  32  cyc_cnt of the first mismatch.
- first_err_data  out  WIDTH  dut_data at the first mismatch.
- done  out  1  RUN compares complete; sticky.
- pass  out  1  done and err_count==0; sticky.
- fail  out  1  err_count>0; sticky, may rise before done.

Behaviour:
- Reset (reset==0, async): all outputs 0; delay line valid bits 0; state WARMUP.
- cyc_cnt is 0 in the first cycle after release and increments by 1 per clock.
- Alignment: exp_valid/exp_data pass through a LATENCY-deep shift register (d_valid/d_data). With LATENCY=0 there is no register, and the compare is against the current inputs. The shift register runs in every state, including WARMUP.
- State WARMUP:
  - No compares.
  - Moves to CHECK at the edge where cyc_cnt becomes WARMUP, so the first compare cycle has cyc_cnt==WARMUP.
- State CHECK: in each cycle with d_valid==1:
  - check_count increments.
  - If dut_data != d_data, err_count increments.
  - On the first mismatch, first_err_cycle and first_err_data are captured. They are never overwritten after that.
  - Cycles with d_valid==0 are skipped and counted nowhere.
- CHECK -> DONE: on the edge that performs compare number RUN. That last compare's result is included. done, and pass if applicable, are registered and visible from the next cycle.
- fail rises the cycle after the first mismatch, independent of done.
- State DONE:
  - No further compares; counters frozen.
  - Flags held until reset.
  - exp_valid is ignored.
- X/Z on dut_data while d_valid==1 in CHECK counts as a mismatch (use !== semantics in simulation).
- Saturation: err_count stops at 16'hFFFF. If check_count reaches RUN, the block stops checking regardless of that limit.
- Reset asserted mid-operation: immediate clear to the reset values; the warm-up restarts from cyc_cnt=0 after release.
- RUN==0: go to DONE directly on leaving WARMUP; pass=1.

Optional Feature:
- Macro: REGRESS_CHECKER_DISPLAY_EN.
- Defined:
  - Each compare prints "cycle:%4d exp:%2d y:%2d %s" (signed values, OK/ERR).
  - On entering DONE, prints "PASS" or "FAIL errors:%0d" and calls $finish.
- Undefined:
  - No system tasks; block is silent and synthesizable.
  - Bench polls done.

Test Plan:
1. WIDTH=8, LATENCY=1, WARMUP=20, RUN=10; DUT is a register of a=8'h0c, exp_data=8'h0c, exp_valid=1 -> checks at cyc_cnt 20..29; done=1, pass=1 at cyc_cnt=30; check_count=10, err_count=0.
2. Same as 1, with dut_data forced to 8'h0d only at cyc_cnt=25 -> fail=1 at cyc 26; done at 30; pass=0; err_count=1; first_err_cycle=25; first_err_data=8'h0d.
3. Same as 1, with dut_data=8'hxx for cyc_cnt<20 -> err_count=0, pass=1 (warm-up suppression).
4. Same as 1, with exp_valid toggling 1,0,1,0 from cyc 0 -> a check every other cycle; check_count=10; done at cyc_cnt=40; pass=1.
5. Same as 1, with reset pulled low at cyc_cnt=24 for 2 cycles -> all outputs 0 immediately; after release cyc_cnt restarts at 0; done/pass again at cyc_cnt=30.
6. LATENCY=0, combinational DUT y=a, a=8'hc3 -> pass=1 at cyc 30. LATENCY=0 against a registered DUT -> first compare fails, and first_err_cycle=20 only if the data changes at that cycle.
